// File: rtl/control_unit.sv
// Mini SRC hardwired control sequencer: one Moore FSM for fetch, decode and execute, driving datapath strobes.
// Latency: strobes decode combinationally from state and IRout; fetch is 3+MEM_WAIT cycles; stop is honoured only at fetch boundaries.
module control_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IRout,
  input  logic        CONFF_out,
  input  logic        stop,
  output logic        run,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout_en,
  output logic        IncPC,
  output logic        PC_en,
  output logic        IR_en,
  output logic        Yin,
  output logic        HIout,
  output logic        HIin,
  output logic        LOout,
  output logic        LOin,
  output logic        Cout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Zin,
  output logic        MDRout,
  output logic        MDRin,
  output logic        MARin,
  output logic        memRead,
  output logic        memWrite,
  output logic        inPort_en,
  output logic        outPort_en,
  output logic        inPortOut,
  output logic        CONin,
  output logic [4:0]  opcode
);

  typedef enum logic [3:0] {
    S_RESET, S_STOPPED, S_HALTED,
    S_F0, S_F1, S_FW, S_F2,
    S_E0, S_E1, S_E2, S_E3, S_E4,
    S_LW, S_LF
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);
  localparam logic [4:0] OP_ADD    = 5'b00011;

  state_t     state;
  state_t     fetch_next;
  logic [2:0] wcnt;
  logic       wait_done;
  logic [4:0] op;
  logic [4:0] imm_op;
  logic       is_ld, is_ldi, is_st, is_rtype, is_imm, is_muldiv, is_negnot;
  logic       is_br, is_jr, is_jal, is_in, is_out, is_mflo, is_mfhi, is_nop, is_halt;
  logic       one_cycle;
  logic       unused_ir;

  assign op        = IRout[31:27];
  assign unused_ir = ^IRout[26:0];

  assign is_ld     = (op == 5'd0);
  assign is_ldi    = (op == 5'd1);
  assign is_st     = (op == 5'd2);
  assign is_rtype  = (op >= 5'd3) && (op <= 5'd11);
  assign is_imm    = (op >= 5'd12) && (op <= 5'd14);
  assign is_muldiv = (op == 5'd15) || (op == 5'd16);
  assign is_negnot = (op == 5'd17) || (op == 5'd18);
  assign is_br     = (op == 5'd19);
  assign is_jr     = (op == 5'd20);
  assign is_jal    = (op == 5'd21);
  assign is_in     = (op == 5'd22);
  assign is_out    = (op == 5'd23);
  assign is_mflo   = (op == 5'd24);
  assign is_mfhi   = (op == 5'd25);
  assign is_halt   = (op == 5'd27);
  assign is_nop    = (op == 5'd26) || (op >= 5'd28);
  assign one_cycle = is_jr || is_in || is_out || is_mflo || is_mfhi;

  always_comb begin
    case (op)
      5'd12:   imm_op = OP_ADD;
      5'd13:   imm_op = 5'b01010;
      default: imm_op = 5'b01011;
    endcase
  end

  // Every path back to F0 passes through the stop check.
  assign fetch_next = stop ? S_STOPPED : S_F0;
  assign wait_done  = (wcnt == WAIT_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_RESET;
      wcnt  <= 3'd1;
    end else begin
      case (state)
        S_RESET:   state <= S_F0;
        S_STOPPED: if (!stop) state <= S_F0;
        S_HALTED:  state <= S_HALTED;
        S_F0:      state <= S_F1;
        S_F1: begin
          state <= S_FW;
          wcnt  <= 3'd1;
        end
        S_FW: begin
          if (wait_done) state <= S_F2;
          else           wcnt  <= wcnt + 3'd1;
        end
        // Dispatch reads IRout while the fetched word is being latched.
        S_F2: begin
          if (is_halt)     state <= S_HALTED;
          else if (is_nop) state <= fetch_next;
          else             state <= S_E0;
        end
        S_E0: state <= one_cycle ? fetch_next : S_E1;
        S_E1: state <= (is_negnot || is_jal) ? fetch_next : S_E2;
        S_E2: begin
          if (is_ld) begin
            state <= S_LW;
            wcnt  <= 3'd1;
          end else if (is_st || is_muldiv || is_br) begin
            state <= S_E3;
          end else begin
            state <= fetch_next;
          end
        end
        S_E3: state <= is_st ? S_E4 : fetch_next;
        S_E4: state <= fetch_next;
        S_LW: begin
          if (wait_done) state <= S_LF;
          else           wcnt  <= wcnt + 3'd1;
        end
        S_LF:    state <= fetch_next;
        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    run = 1'b1;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout_en = 1'b0; IncPC = 1'b0; PC_en = 1'b0; IR_en = 1'b0;
    Yin = 1'b0; HIout = 1'b0; HIin = 1'b0; LOout = 1'b0; LOin = 1'b0;
    Cout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; Zin = 1'b0;
    MDRout = 1'b0; MDRin = 1'b0; MARin = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    inPort_en = 1'b0; outPort_en = 1'b0; inPortOut = 1'b0; CONin = 1'b0;
    opcode = OP_ADD;
    case (state)
      S_F0: begin PCout_en = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_F1: begin Zlowout = 1'b1; PC_en = 1'b1; memRead = 1'b1; end
      S_FW: begin memRead = 1'b1; MDRin = wait_done; end
      S_F2: begin MDRout = 1'b1; IR_en = 1'b1; end
      S_E0: begin
        if (is_rtype || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_negnot) begin
          Grb = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1;
        end else if (is_ld || is_ldi || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (is_jr) begin
          Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1;
        end else if (is_jal) begin
          PCout_en = 1'b1; Grb = 1'b1; Rin = 1'b1;
        end else if (is_in) begin
          inPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_out) begin
          Gra = 1'b1; Rout = 1'b1; outPort_en = 1'b1;
        end else if (is_mfhi) begin
          HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_mflo) begin
          LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_E1: begin
        if (is_rtype) begin
          Grc = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1;
        end else if (is_imm) begin
          Cout = 1'b1; opcode = imm_op; Zin = 1'b1;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1;
        end else if (is_negnot) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_ld || is_ldi || is_st) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (is_br) begin
          PCout_en = 1'b1; Yin = 1'b1;
        end else if (is_jal) begin
          Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1;
        end
      end
      S_E2: begin
        if (is_rtype || is_imm || is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1;
        end
      end
      S_E3: begin
        if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          Zlowout = 1'b1; PC_en = CONFF_out;
        end
      end
      S_E4: memWrite = 1'b1;
      S_LW: begin memRead = 1'b1; MDRin = wait_done; end
      S_LF: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      default: begin
        run    = 1'b0;
        opcode = 5'b00000;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe tables for MEM_WAIT=1 and MEM_WAIT=2 instances,
// plus hand sequences for async clear mid-instruction and halt/restart.
module tb_control_unit;

  typedef struct packed {
    logic [28:0] s;
    logic [4:0]  opcode;
  } ctl_t;

  typedef struct {
    string       nm;
    logic [31:0] ir;
    logic        cf;
    logic        st;
    int          sel;
    ctl_t        e;
  } vec_t;

  localparam logic [28:0] RUN = 29'd1 << 28, GRA = 29'd1 << 27, GRB = 29'd1 << 26, GRC = 29'd1 << 25;
  localparam logic [28:0] RIN = 29'd1 << 24, ROUT = 29'd1 << 23, BAOUT = 29'd1 << 22, PCOUT = 29'd1 << 21;
  localparam logic [28:0] INCPC = 29'd1 << 20, PCEN = 29'd1 << 19, IREN = 29'd1 << 18, YIN = 29'd1 << 17;
  localparam logic [28:0] HIOUT = 29'd1 << 16, HIIN = 29'd1 << 15, LOOUT = 29'd1 << 14, LOIN = 29'd1 << 13;
  localparam logic [28:0] COUT = 29'd1 << 12, ZHIGH = 29'd1 << 11, ZLOW = 29'd1 << 10, ZIN = 29'd1 << 9;
  localparam logic [28:0] MDROUT = 29'd1 << 8, MDRIN = 29'd1 << 7, MARIN = 29'd1 << 6, MEMRD = 29'd1 << 5;
  localparam logic [28:0] MEMWR = 29'd1 << 4, INPEN = 29'd1 << 3, OUTPEN = 29'd1 << 2, INPOUT = 29'd1 << 1;
  localparam logic [28:0] CONIN = 29'd1;
  localparam ctl_t ZERO = '0;

  logic        clock, clear, CONFF_out, stop;
  logic [31:0] IRout;
  wire  [33:0] w1, w2;
  ctl_t        a1, a2;
  int          errors, checks;
  vec_t        tbl[$];

  assign a1 = w1;
  assign a2 = w2;

  control_unit #(.MEM_WAIT(1)) dut1 (
    .clock(clock), .clear(clear), .IRout(IRout), .CONFF_out(CONFF_out), .stop(stop),
    .run(w1[33]), .Gra(w1[32]), .Grb(w1[31]), .Grc(w1[30]), .Rin(w1[29]), .Rout(w1[28]),
    .BAout(w1[27]), .PCout_en(w1[26]), .IncPC(w1[25]), .PC_en(w1[24]), .IR_en(w1[23]),
    .Yin(w1[22]), .HIout(w1[21]), .HIin(w1[20]), .LOout(w1[19]), .LOin(w1[18]), .Cout(w1[17]),
    .Zhighout(w1[16]), .Zlowout(w1[15]), .Zin(w1[14]), .MDRout(w1[13]), .MDRin(w1[12]),
    .MARin(w1[11]), .memRead(w1[10]), .memWrite(w1[9]), .inPort_en(w1[8]), .outPort_en(w1[7]),
    .inPortOut(w1[6]), .CONin(w1[5]), .opcode(w1[4:0])
  );

  control_unit #(.MEM_WAIT(2)) dut2 (
    .clock(clock), .clear(clear), .IRout(IRout), .CONFF_out(CONFF_out), .stop(stop),
    .run(w2[33]), .Gra(w2[32]), .Grb(w2[31]), .Grc(w2[30]), .Rin(w2[29]), .Rout(w2[28]),
    .BAout(w2[27]), .PCout_en(w2[26]), .IncPC(w2[25]), .PC_en(w2[24]), .IR_en(w2[23]),
    .Yin(w2[22]), .HIout(w2[21]), .HIin(w2[20]), .LOout(w2[19]), .LOin(w2[18]), .Cout(w2[17]),
    .Zhighout(w2[16]), .Zlowout(w2[15]), .Zin(w2[14]), .MDRout(w2[13]), .MDRin(w2[12]),
    .MARin(w2[11]), .memRead(w2[10]), .memWrite(w2[9]), .inPort_en(w2[8]), .outPort_en(w2[7]),
    .inPortOut(w2[6]), .CONin(w2[5]), .opcode(w2[4:0])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required finish");
    $fatal(1, "timeout");
  end

  function automatic ctl_t mk(input logic [28:0] s, input logic [4:0] op = 5'b00011);
    ctl_t c;
    c.s = RUN | s;
    c.opcode = op;
    return c;
  endfunction

  task automatic check(input string nm, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (diff %h)", nm, act, exp, act ^ exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] ir, input logic cf, input logic st,
                      input int sel, input ctl_t e);
    vec_t v;
    v.nm = nm; v.ir = ir; v.cf = cf; v.st = st; v.sel = sel; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic ex(input string nm, input logic [31:0] ir, input int sel, input ctl_t e);
    push(nm, ir, 1'b0, 1'b0, sel, e);
  endtask

  task automatic fetch(input string nm, input logic [31:0] ir, input int sel);
    int mw;
    mw = (sel == 1) ? 1 : 2;
    ex({nm, ".F0"}, ir, sel, mk(PCOUT | MARIN | INCPC | ZIN));
    ex({nm, ".F1"}, ir, sel, mk(ZLOW | PCEN | MEMRD));
    for (int i = 1; i <= mw; i++)
      ex($sformatf("%s.W%0d", nm, i), ir, sel, mk(MEMRD | ((i == mw) ? MDRIN : 29'd0)));
    ex({nm, ".F2"}, ir, sel, mk(MDROUT | IREN));
  endtask

  task automatic do_reset();
    clear = 1'b1; stop = 1'b0; CONFF_out = 1'b0;
    @(negedge clock);
    check("reset_dut1", a1, ZERO);
    check("reset_dut2", a2, ZERO);
    @(posedge clock); #1;
    clear = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic build_table();
    fetch("add", 32'h18918000, 1);
    ex("add.E0", 32'h18918000, 1, mk(GRB | ROUT | YIN));
    ex("add.E1", 32'h18918000, 1, mk(GRC | ROUT | ZIN, 5'b00011));
    ex("add.E2", 32'h18918000, 1, mk(ZLOW | GRA | RIN));
    fetch("sub", 32'h20000000, 1);
    ex("sub.E0", 32'h20000000, 1, mk(GRB | ROUT | YIN));
    ex("sub.E1", 32'h20000000, 1, mk(GRC | ROUT | ZIN, 5'b00100));
    ex("sub.E2", 32'h20000000, 1, mk(ZLOW | GRA | RIN));
    fetch("addi", 32'h60000000, 1);
    ex("addi.E0", 32'h60000000, 1, mk(GRB | ROUT | YIN));
    ex("addi.E1", 32'h60000000, 1, mk(COUT | ZIN, 5'b00011));
    ex("addi.E2", 32'h60000000, 1, mk(ZLOW | GRA | RIN));
    fetch("ori", 32'h70000000, 1);
    ex("ori.E0", 32'h70000000, 1, mk(GRB | ROUT | YIN));
    ex("ori.E1", 32'h70000000, 1, mk(COUT | ZIN, 5'b01011));
    ex("ori.E2", 32'h70000000, 1, mk(ZLOW | GRA | RIN));
    fetch("mul", 32'h80000000, 1);
    ex("mul.E0", 32'h80000000, 1, mk(GRA | ROUT | YIN));
    ex("mul.E1", 32'h80000000, 1, mk(GRB | ROUT | ZIN, 5'b10000));
    ex("mul.E2", 32'h80000000, 1, mk(ZLOW | LOIN));
    ex("mul.E3", 32'h80000000, 1, mk(ZHIGH | HIIN));
    fetch("not", 32'h90000000, 1);
    ex("not.E0", 32'h90000000, 1, mk(GRB | ROUT | ZIN, 5'b10010));
    ex("not.E1", 32'h90000000, 1, mk(ZLOW | GRA | RIN));
    fetch("ldi", 32'h08000000, 1);
    ex("ldi.E0", 32'h08000000, 1, mk(GRB | BAOUT | YIN));
    ex("ldi.E1", 32'h08000000, 1, mk(COUT | ZIN));
    ex("ldi.E2", 32'h08000000, 1, mk(ZLOW | GRA | RIN));
    for (int c = 0; c < 2; c++) begin
      fetch($sformatf("br%0d", c), 32'h98000000, 1);
      push($sformatf("br%0d.E0", c), 32'h98000000, c[0], 1'b0, 1, mk(GRA | ROUT | CONIN));
      push($sformatf("br%0d.E1", c), 32'h98000000, c[0], 1'b0, 1, mk(PCOUT | YIN));
      push($sformatf("br%0d.E2", c), 32'h98000000, c[0], 1'b0, 1, mk(COUT | ZIN));
      push($sformatf("br%0d.E3", c), 32'h98000000, c[0], 1'b0, 1, mk(ZLOW | (c[0] ? PCEN : 29'd0)));
    end
    fetch("jr", 32'hA0000000, 1);
    ex("jr.E0", 32'hA0000000, 1, mk(GRA | ROUT | PCEN));
    fetch("jal", 32'hA8000000, 1);
    ex("jal.E0", 32'hA8000000, 1, mk(PCOUT | GRB | RIN));
    ex("jal.E1", 32'hA8000000, 1, mk(GRA | ROUT | PCEN));
    fetch("in", 32'hB0000000, 1);
    ex("in.E0", 32'hB0000000, 1, mk(INPOUT | GRA | RIN));
    fetch("out", 32'hB8000000, 1);
    ex("out.E0", 32'hB8000000, 1, mk(GRA | ROUT | OUTPEN));
    fetch("mfhi", 32'hC8000000, 1);
    ex("mfhi.E0", 32'hC8000000, 1, mk(HIOUT | GRA | RIN));
    fetch("mflo", 32'hC0000000, 1);
    ex("mflo.E0", 32'hC0000000, 1, mk(LOOUT | GRA | RIN));
    fetch("nop", 32'hD0000000, 1);
    fetch("op31", 32'hF8000000, 1);
    // stop raised in E1 only takes effect at the next fetch boundary
    fetch("stp", 32'h18918000, 1);
    ex("stp.E0", 32'h18918000, 1, mk(GRB | ROUT | YIN));
    push("stp.E1", 32'h18918000, 1'b0, 1'b1, 1, mk(GRC | ROUT | ZIN));
    push("stp.E2", 32'h18918000, 1'b0, 1'b1, 1, mk(ZLOW | GRA | RIN));
    push("stp.STOPPED_a", 32'h18918000, 1'b0, 1'b1, 1, ZERO);
    push("stp.STOPPED_b", 32'h18918000, 1'b0, 1'b0, 1, ZERO);
    fetch("resume", 32'hD0000000, 1);
    // MEM_WAIT=2 instance
    fetch("ld", 32'h00000000, 2);
    ex("ld.E0", 32'h00000000, 2, mk(GRB | BAOUT | YIN));
    ex("ld.E1", 32'h00000000, 2, mk(COUT | ZIN));
    ex("ld.E2", 32'h00000000, 2, mk(ZLOW | MARIN));
    ex("ld.W1", 32'h00000000, 2, mk(MEMRD));
    ex("ld.W2", 32'h00000000, 2, mk(MEMRD | MDRIN));
    ex("ld.E5", 32'h00000000, 2, mk(MDROUT | GRA | RIN));
    fetch("st", 32'h10000000, 2);
    ex("st.E0", 32'h10000000, 2, mk(GRB | BAOUT | YIN));
    ex("st.E1", 32'h10000000, 2, mk(COUT | ZIN));
    ex("st.E2", 32'h10000000, 2, mk(ZLOW | MARIN));
    ex("st.E3", 32'h10000000, 2, mk(GRA | ROUT | MDRIN));
    ex("st.E4", 32'h10000000, 2, mk(MEMWR));
    fetch("add2", 32'h18918000, 2);
    ex("add2.E0", 32'h18918000, 2, mk(GRB | ROUT | YIN));
    ex("add2.E1", 32'h18918000, 2, mk(GRC | ROUT | ZIN));
    ex("add2.E2", 32'h18918000, 2, mk(ZLOW | GRA | RIN));
    fetch("nop2", 32'hD0000000, 2);
  endtask

  initial begin
    int prev_sel;
    errors = 0; checks = 0;
    clear = 1'b1; stop = 1'b0; CONFF_out = 1'b0; IRout = 32'h0;
    build_table();
    prev_sel = 0;
    foreach (tbl[i]) begin
      if (tbl[i].sel != prev_sel) do_reset();
      prev_sel = tbl[i].sel;
      IRout = tbl[i].ir; CONFF_out = tbl[i].cf; stop = tbl[i].st;
      @(negedge clock);
      check(tbl[i].nm, (tbl[i].sel == 1) ? a1 : a2, tbl[i].e);
      @(posedge clock); #1;
    end

    // clear asserted part-way through E1 of an add
    do_reset();
    IRout = 32'h18918000;
    repeat (5) @(posedge clock);
    #1;
    check("mid_E1", a1, mk(GRC | ROUT | ZIN));
    clear = 1'b1;
    #1;
    check("clear_async", a1, ZERO);
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    check("clear_released_reset", a1, ZERO);
    @(negedge clock);
    check("clear_first_F0", a1, mk(PCOUT | MARIN | INCPC | ZIN));

    // halt parks the sequencer; stop is irrelevant there
    do_reset();
    IRout = 32'hD8000000;
    repeat (4) @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      stop = i[0];
      @(negedge clock);
      check($sformatf("halted_%0d", i), a1, ZERO);
      @(posedge clock);
    end
    stop = 1'b0;
    IRout = 32'h18918000;
    #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    check("halt_clear_reset", a1, ZERO);
    @(negedge clock);
    check("halt_restart_F0", a1, mk(PCOUT | MARIN | INCPC | ZIN));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
